// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN stream host: default widths, FSM state
// encoding and the SEND-exit decision used at start and at end of SEND.
package dnn_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int AW_DEFAULT = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    function automatic state_t after_send(input logic dst_pending);
        return dst_pending ? ST_RECV : ST_FIN;
    endfunction

endpackage

// File: rtl/dnn_skid_fifo.sv
// Two-entry FIFO holding memory read data ahead of the outgoing stream.
// Supports simultaneous push and pop; the caller guarantees no overflow.
module dnn_skid_fifo #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] data
);

    logic [1:0][DW-1:0] entry_q, entry_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + 2'(push) - 2'(pop);
        if (push) begin
            entry_d[wr_ptr_q] = push_data;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage itself is not reset; occupancy is tracked by count_q, which is.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign full  = count_q[1];
    assign empty = (count_q == 2'd0);
    assign data  = entry_q[rd_ptr_q];

endmodule

// File: rtl/dnn_stream_host.sv
// Batch host: streams src_len words from memory to an accelerator, then
// writes up to dst_len returned words back to memory, flagging length errors.
module dnn_stream_host
    import dnn_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [AW-1:0] src_len,
    input  logic [AW-1:0] dst_len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_data,
    output logic          src_valid,
    output logic [DW-1:0] src_data,
    output logic          src_last,
    input  logic          src_ready,
    input  logic          dst_valid,
    input  logic [DW-1:0] dst_data,
    input  logic          dst_last,
    output logic          dst_ready
);

    state_t        state_q, state_d;
    logic [AW-1:0] src_base_q, src_base_d;
    logic [AW-1:0] src_len_q, src_len_d;
    logic [AW-1:0] dst_base_q, dst_base_d;
    logic [AW-1:0] dst_len_q, dst_len_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [AW-1:0] tx_cnt_q, tx_cnt_d;
    logic [AW-1:0] rx_cnt_q, rx_cnt_d;
    logic          rd_pend_q, rd_pend_d;
    logic          err_q, err_d;

    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic [2:0]    rd_slots;
    logic          rx_final;

    dnn_skid_fifo #(.DW(DW)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rd_pend_q),
        .push_data(mem_rd_data),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .data     (fifo_data)
    );

    always_comb begin
        state_d    = state_q;
        src_base_d = src_base_q;
        src_len_d  = src_len_q;
        dst_base_d = dst_base_q;
        dst_len_d  = dst_len_q;
        rd_cnt_d   = rd_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        err_d      = err_q;

        busy        = (state_q != ST_IDLE);
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        dst_ready   = 1'b0;
        rx_final    = (rx_cnt_q == dst_len_q - AW'(1));

        src_valid = (state_q == ST_SEND) && !fifo_empty;
        src_data  = src_valid ? fifo_data : '0;
        src_last  = src_valid && (tx_cnt_q == src_len_q - AW'(1));
        fifo_pop  = src_valid && src_ready;

        // Slots still claimed after this cycle's pop; a new read may fill the last free one.
        rd_slots = {1'b0, fifo_full, !fifo_empty && !fifo_full} + {2'b0, rd_pend_q} - {2'b0, fifo_pop};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_base_d = src_base;
                    src_len_d  = src_len;
                    dst_base_d = dst_base;
                    dst_len_d  = dst_len;
                    rd_cnt_d   = '0;
                    tx_cnt_d   = '0;
                    rx_cnt_d   = '0;
                    err_d      = 1'b0;
                    state_d    = (src_len != '0) ? ST_SEND : after_send(dst_len != '0);
                end
            end
            ST_SEND: begin
                if ((rd_cnt_q != src_len_q) && (rd_slots < 3'd2)) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = src_base_q + rd_cnt_q;
                    rd_cnt_d    = rd_cnt_q + AW'(1);
                end
                if (fifo_pop) begin
                    tx_cnt_d = tx_cnt_q + AW'(1);
                    if (src_last) begin
                        state_d = after_send(dst_len_q != '0);
                    end
                end
            end
            ST_RECV: begin
                dst_ready = 1'b1;
                if (dst_valid) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = dst_base_q + rx_cnt_q;
                    mem_wr_data = dst_data;
                    rx_cnt_d    = rx_cnt_q + AW'(1);
                    if (dst_last || rx_final) begin
                        state_d = ST_FIN;
                    end
                    if (dst_last != rx_final) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        rd_pend_d = mem_rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            src_base_q <= '0;
            src_len_q  <= '0;
            dst_base_q <= '0;
            dst_len_q  <= '0;
            rd_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            rd_pend_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_base_q <= src_base_d;
            src_len_q  <= src_len_d;
            dst_base_q <= dst_base_d;
            dst_len_q  <= dst_len_d;
            rd_cnt_q   <= rd_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            rd_pend_q  <= rd_pend_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_dnn_stream_host.sv
// Directed bench for dnn_stream_host: memory model, stream driver and
// negedge monitors feed logs that the linear test sequence checks.
module tb_dnn_stream_host;

    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] src_base, dst_base, src_len, dst_len;
    logic          busy, done, err;
    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [DW-1:0] mem_rd_data, mem_wr_data;
    logic          src_valid, src_last, src_ready;
    logic [DW-1:0] src_data;
    logic          dst_valid, dst_last, dst_ready;
    logic [DW-1:0] dst_data;

    dnn_stream_host #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_base(src_base), .dst_base(dst_base), .src_len(src_len), .dst_len(dst_len),
        .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
        .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last), .dst_ready(dst_ready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [DW-1:0] src_word(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {20'd0, a};
    endfunction

    function automatic logic [DW-1:0] dst_word(input int k);
        case (k)
            0: return 32'h3F80_0000;
            1: return 32'h4000_0000;
            2: return 32'h4040_0000;
            default: return 32'h4080_0000;
        endcase
    endfunction

    // Memory read port, fixed one-cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= src_word(mem_rd_addr);
    end

    int            cyc = 0;
    int            start_cyc = 0;
    int            first_valid = -1;
    int            done_cnt = 0, busy_cnt = 0, rdy_cnt = 0, stall_bad = 0;
    logic [DW-1:0] beat_data[$];
    logic          beat_last[$];
    int            beat_cyc[$];
    logic [AW-1:0] rd_addr_log[$];
    logic [AW-1:0] wr_addr_log[$];
    logic [DW-1:0] wr_data_log[$];
    logic          prev_stall = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start && !busy) start_cyc = cyc;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (dst_ready) rdy_cnt++;
        if (mem_rd_en) rd_addr_log.push_back(mem_rd_addr);
        if (mem_wr_en) begin
            wr_addr_log.push_back(mem_wr_addr);
            wr_data_log.push_back(mem_wr_data);
        end
        if (src_valid && first_valid < 0) first_valid = cyc - start_cyc;
        if (src_valid && src_ready) begin
            beat_data.push_back(src_data);
            beat_last.push_back(src_last);
            beat_cyc.push_back(cyc);
        end
        if (prev_stall && !(src_valid && src_data === prev_data && src_last === prev_last)) stall_bad++;
        prev_stall = src_valid && !src_ready;
        prev_data  = src_data;
        prev_last  = src_last;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        beat_data.delete(); beat_last.delete(); beat_cyc.delete();
        rd_addr_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
        done_cnt = 0; busy_cnt = 0; rdy_cnt = 0; stall_bad = 0; first_valid = -1;
    endtask

    // Runs one batch; dst words are offered from cycle 1 and advance on handshake.
    task automatic run(input logic [AW-1:0] sb, input logic [AW-1:0] sl,
                       input logic [AW-1:0] db, input logic [AW-1:0] dl,
                       input bit toggle, input int n_dst, input int last_idx);
        int  k;
        bit  hs;
        k = 0;
        clear_logs();
        src_base = sb; src_len = sl; dst_base = db; dst_len = dl;
        src_ready = toggle ? 1'b0 : 1'b1;
        dst_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200 && done_cnt == 0; c++) begin
            src_ready = toggle ? ~src_ready : 1'b1;
            dst_valid = (k < n_dst);
            dst_data  = dst_word(k);
            dst_last  = (k == last_idx);
            @(negedge clk);
            hs = dst_valid && dst_ready;
            tick();
            if (hs) k++;
        end
        dst_valid = 1'b0;
        dst_last  = 1'b0;
        src_ready = 1'b1;
        tick();
        check("done_seen_in_budget", 64'(done_cnt != 0), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; src_ready = 1'b1;
        dst_valid = 1'b0; dst_last = 1'b0; dst_data = '0;
        src_base = '0; dst_base = '0; src_len = '0; dst_len = '0;
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_outs", 64'({mem_rd_en, mem_wr_en, src_valid, src_last, dst_ready}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic batch: 4 words out, 1.0/2.0 back with last on the second.
        run(12'd16, 12'd4, 12'd100, 12'd2, 1'b0, 2, 1);
        check("t1_beats", 64'(beat_data.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_data%0d", i), 64'(beat_data[i]), 64'(src_word(12'(16 + i))));
            check($sformatf("t1_last%0d", i), 64'(beat_last[i]), 64'(i == 3));
            check($sformatf("t1_cyc%0d", i), 64'(beat_cyc[i] - beat_cyc[0]), 64'(i));
        end
        check("t1_first_valid", 64'(first_valid), 64'd3);
        check("t1_reads", 64'(rd_addr_log.size()), 64'd4);
        check("t1_writes", 64'(wr_addr_log.size()), 64'd2);
        check("t1_wa0", 64'(wr_addr_log[0]), 64'd100);
        check("t1_wd0", 64'(wr_data_log[0]), 64'h3F80_0000);
        check("t1_wa1", 64'(wr_addr_log[1]), 64'd101);
        check("t1_wd1", 64'(wr_data_log[1]), 64'h4000_0000);
        check("t1_done", 64'(done_cnt), 64'd1);
        check("t1_busy", 64'(busy_cnt), 64'd9);
        check("t1_dst_ready", 64'(rdy_cnt), 64'd2);
        check("t1_err", 64'(err), 64'd0);

        // Stalling sink: src_ready toggles every cycle.
        run(12'd40, 12'd6, 12'd0, 12'd0, 1'b1, 0, -1);
        check("t2_beats", 64'(beat_data.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_data%0d", i), 64'(beat_data[i]), 64'(src_word(12'(40 + i))));
            check($sformatf("t2_last%0d", i), 64'(beat_last[i]), 64'(i == 5));
        end
        check("t2_reads", 64'(rd_addr_log.size()), 64'd6);
        check("t2_stall_stable", 64'(stall_bad), 64'd0);
        check("t2_writes", 64'(wr_addr_log.size()), 64'd0);
        check("t2_done", 64'(done_cnt), 64'd1);

        // Early dst_last: 2 of 4 words, error flagged.
        run(12'd0, 12'd0, 12'd200, 12'd4, 1'b0, 4, 1);
        check("t3_writes", 64'(wr_addr_log.size()), 64'd2);
        check("t3_wa1", 64'(wr_addr_log[1]), 64'd201);
        check("t3_reads", 64'(rd_addr_log.size()), 64'd0);
        check("t3_done", 64'(done_cnt), 64'd1);
        check("t3_err", 64'(err), 64'd1);

        // Missing dst_last on the final word also flags an error.
        run(12'd0, 12'd0, 12'd300, 12'd3, 1'b0, 4, -1);
        check("t3b_writes", 64'(wr_addr_log.size()), 64'd3);
        check("t3b_wd2", 64'(wr_data_log[2]), 64'h4040_0000);
        check("t3b_err", 64'(err), 64'd1);

        // Empty batch clears err.
        run(12'd0, 12'd0, 12'd0, 12'd0, 1'b0, 0, -1);
        check("t4_err_cleared", 64'(err), 64'd0);
        check("t4_busy", 64'(busy_cnt), 64'd1);
        check("t4_done", 64'(done_cnt), 64'd1);
        check("t4_activity", 64'(rd_addr_log.size() + wr_addr_log.size() + beat_data.size() + rdy_cnt), 64'd0);

        // Source address wrap.
        run(12'd4094, 12'd4, 12'd0, 12'd0, 1'b0, 0, -1);
        check("t5_reads", 64'(rd_addr_log.size()), 64'd4);
        check("t5_ra0", 64'(rd_addr_log[0]), 64'd4094);
        check("t5_ra1", 64'(rd_addr_log[1]), 64'd4095);
        check("t5_ra2", 64'(rd_addr_log[2]), 64'd0);
        check("t5_ra3", 64'(rd_addr_log[3]), 64'd1);
        check("t5_data2", 64'(beat_data[2]), 64'(src_word(12'd0)));

        // Reset mid-SEND abandons the batch.
        clear_logs();
        src_base = 12'd500; src_len = 12'd8; dst_base = 12'd0; dst_len = 12'd2;
        src_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("t6_midsend_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_status", 64'({busy, done, err}), 64'd0);
        check("t6_rst_outs", 64'({mem_rd_en, mem_wr_en, src_valid, src_last, dst_ready}), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        done_cnt = 0;
        tick(); tick(); tick();
        check("t6_no_done", 64'(done_cnt), 64'd0);
        check("t6_idle", 64'(busy), 64'd0);

        run(12'd60, 12'd3, 12'd70, 12'd1, 1'b0, 1, 0);
        check("t6_beats", 64'(beat_data.size()), 64'd3);
        check("t6_data0", 64'(beat_data[0]), 64'(src_word(12'd60)));
        check("t6_last2", 64'(beat_last[2]), 64'd1);
        check("t6_writes", 64'(wr_addr_log.size()), 64'd1);
        check("t6_wa0", 64'(wr_addr_log[0]), 64'd70);
        check("t6_done", 64'(done_cnt), 64'd1);
        check("t6_err", 64'(err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dnn_stream_host.md
DNN_STREAM_HOST -- requirements
Module: dnn_stream_host

Interface
REQ-001 SHALL have parameter DW, default 32, meaning stream and memory data width (IEEE-754 single bit pattern).
REQ-002 SHALL have parameter AW, default 12, meaning memory address and length width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to run one batch transfer.
REQ-006 SHALL have ports src_base, dst_base, src_len, dst_len  input  AW each  memory bases and word counts; sampled on accepted start.
REQ-007 SHALL have ports busy  output  1, done  output  1, err  output  1  status.
REQ-008 SHALL have ports mem_rd_en  output  1, mem_rd_addr  output  AW, mem_rd_data  input  DW  read port with fixed 1-cycle latency.
REQ-009 SHALL have ports mem_wr_en  output  1, mem_wr_addr  output  AW, mem_wr_data  output  DW  write port.
REQ-010 SHALL have ports src_valid  output  1, src_data  output  DW, src_last  output  1, src_ready  input  1  stream toward the accelerator.
REQ-011 SHALL have ports dst_valid  input  1, dst_data  input  DW, dst_last  input  1, dst_ready  output  1  stream from the accelerator.

Function
REQ-012 SHALL implement FSM states IDLE, SEND, RECV, FIN; start is accepted only in IDLE; start in any other state is ignored.
REQ-013 SHALL, on accepted start, go to SEND if src_len!=0, else RECV if dst_len!=0, else FIN.
REQ-014 SHALL, in SEND, read words src_base+0 .. src_base+src_len-1 in order; addresses wrap modulo 2^AW.
REQ-015 SHALL hold read data in a 2-entry FIFO and issue mem_rd_en only when FIFO occupancy plus reads in flight is below 2; no word is ever dropped or duplicated.
REQ-016 SHALL assert src_valid in the third cycle after the start edge when src_ready is high; sustained throughput SHALL be 1 word/cycle with src_ready held high.
REQ-017 SHALL count a src word as transferred only when src_valid and src_ready are both high; src_data, src_valid and src_last SHALL stay stable while src_valid is high and src_ready is low.
REQ-018 SHALL assert src_last with exactly the final word (index src_len-1) and never otherwise.
REQ-019 SHALL leave SEND after the final handshake and enter RECV if dst_len!=0, else FIN.
REQ-020 SHALL drive dst_ready high in every RECV cycle and low in all other states.
REQ-021 SHALL write each accepted dst word in the same cycle: mem_wr_en=1, mem_wr_addr=dst_base+count (modulo 2^AW), mem_wr_data=dst_data.
REQ-022 SHALL end RECV on whichever comes first: an accepted word with dst_last, or the dst_len-th accepted word.
REQ-023 SHALL set err when dst_last arrives on a word other than index dst_len-1, or when the dst_len-th word arrives without dst_last; err SHALL hold until the next accepted start clears it.
REQ-024 SHALL, in FIN, pulse done high for exactly one cycle and return to IDLE.
REQ-025 SHALL hold busy high from the cycle after the accepted start through the done cycle inclusive.
REQ-026 SHALL drive mem_rd_en, mem_wr_en, src_valid, src_last and dst_ready low in IDLE.

Reset
REQ-027 SHALL, while rst_n is low, force state IDLE, flush the FIFO and counters, and hold busy, done, err, mem_rd_en, mem_wr_en, src_valid, src_last and dst_ready at 0.
REQ-028 SHALL abandon any transfer in progress when reset is asserted mid-operation; no done pulse SHALL follow, and the next start after release SHALL run normally.

Structure
REQ-029 SHALL take the FSM state enum and the DW/AW defaults from the shared package dnn_pkg.
REQ-030 SHALL implement the 2-entry FIFO as the sub-module dnn_skid_fifo (push, pop, full, empty, data), instantiated once.

Verification
REQ-031 SHALL cover: src_len=4, dst_len=2, src_ready=1, dst_valid words 1.0/2.0 with last on the 2nd -> 4 consecutive src beats with last on beat 4, 2 writes at dst_base, done=1 once, err=0.
REQ-032 SHALL cover: src_len=6 with src_ready toggling 1/0 every cycle -> all 6 words in order with stable data during stalls, no extra mem_rd_en beyond 6.
REQ-033 SHALL cover: dst_len=4 with dst_last on the 2nd word -> 2 writes, err=1, done pulse; the next start clears err.
REQ-034 SHALL cover: src_len=0 and dst_len=0 -> no stream or memory activity, busy high 1 cycle, done pulse.
REQ-035 SHALL cover: src_base=4094 and src_len=4 -> read addresses 4094, 4095, 0, 1.
REQ-036 SHALL cover: rst_n pulsed low mid-SEND -> all outputs 0, no done pulse; the following transfer completes correctly.
